uart_receiver: RTL and testbench
================================

// Module: uart_receiver
// PURPOSE
//  UART receive path for the Cyclone IV design; counterpart to the UART transmitter on the same link.
//  Deserialises 8N1 frames (start 0, 8 data LSB first, stop 1, idle high) from the async RX pin.
//  Presents each good byte with a one-cycle strobe and flags frames whose stop bit is bad.
//  Sits between the board RX pin and the byte consumer (loopback/echo logic, command decoder).
// PARAMETERS
//  CLKS_PER_BIT  434  clc cycles per bit (50 MHz / 115200); legal >= 8
// PORTS
//  clc                   in   1  system clock; all logic on posedge
//  res                   in   1  synchronous reset, active-high
//  RX                    in   1  async serial input, idle high
//  word_receiver         out  8  last correctly received byte, held until next good frame
//  priznak_end_receiver  out  1  1-cycle strobe: word_receiver updated this cycle
//  frame_error           out  1  1-cycle strobe: stop bit sampled 0, byte discarded
//  busy                  out  1  high from start-bit detect until return to IDLE
// BEHAVIOUR
//  Reset (res=1 at posedge): state=IDLE, counters=0, shift reg=0, synchroniser FFs=1,
//   word_receiver=0, priznak_end_receiver=0, frame_error=0, busy=0. Applies mid-frame: frame dropped.
//  Input: RX through 2-FF synchroniser -> rx_s; FSM uses rx_s only (2-cycle input delay).
//  Counters: bit_cnt width $clog2(CLKS_PER_BIT); idx 3 bits; HALF = CLKS_PER_BIT/2 (integer div).
//  FSM states / transitions:
//   IDLE   : busy=0. rx_s==0 -> START, bit_cnt=0.
//   START  : count to HALF-1; at that cycle rx_s==0 -> DATA (bit_cnt=0, idx=0);
//            rx_s==1 -> IDLE (glitch rejected, no strobe).
//   DATA   : count to CLKS_PER_BIT-1; at that cycle shift[idx]=rx_s, idx++, bit_cnt=0;
//            after idx 7 sampled -> STOP. Samples land at bit centres.
//   STOP   : count to CLKS_PER_BIT-1; sample rx_s:
//            1 -> word_receiver=shift, priznak_end_receiver=1 next cycle, -> IDLE.
//            0 -> frame_error=1 next cycle, word_receiver unchanged, -> BREAK.
//   BREAK  : wait for rx_s==1, then -> IDLE (line held low never retriggers a frame).
//  Strobes: priznak_end_receiver and frame_error exactly 1 cycle, mutually exclusive.
//  Latency: strobe 1 cycle after stop-bit mid sample, ~9.5 bit times + 3 clc after RX falling edge.
//  Back-to-back frames: return to IDLE at mid stop bit; next start edge in the following
//   half-bit is caught. No minimum idle between frames beyond the stop bit.
//  No FIFO: consumer must take word_receiver before the next strobe (>= 10 bit times).
//  Glitch < HALF cycles low on idle line: rejected in START, busy pulses, no output strobe.
//  busy=1 in START, DATA, STOP, BREAK.
// TESTING  (bench uses CLKS_PER_BIT=16)
//  1 Send 0xA5 (0,1,0,1,0,0,1,0,1,1 on RX) -> one priznak_end_receiver, word_receiver=0xA5,
//    frame_error=0.
//  2 Send 0x00, 0xFF, 0x5A back-to-back, stop bit of 16 cycles only ->
//    3 strobes, bytes in order, no errors.
//  3 Send 0x3C with stop bit driven 0, then hold RX=0 for 40 bit times -> one frame_error,
//    word_receiver keeps prior value, no further strobes until RX returns high.
//  4 RX low pulse of 5 cycles on idle line -> no strobe; busy returns 0; next 0x81 frame
//    received correctly.
//  5 Assert res for 1 cycle mid DATA of 0x77 -> outputs 0, FSM IDLE; following 0xC3 frame
//    -> word_receiver=0xC3.
//  6 Loopback with uart transmitter at same bit rate, 256 random bytes -> all received,
//    zero frame_error.

Source files
------------

// File: rtl/uart_receiver_if.sv
// Receiver-side signal bundle: serial input plus the received-byte outputs.
// The receiver connects through the slave modport and the driver of RX through the master modport.
interface uart_receiver_if;
  logic       RX;
  logic [7:0] word_receiver;
  logic       priznak_end_receiver;
  logic       frame_error;
  logic       busy;

  modport master (
    output RX,
    input  word_receiver, priznak_end_receiver, frame_error, busy
  );

  modport slave (
    input  RX,
    output word_receiver, priznak_end_receiver, frame_error, busy
  );
endinterface

// File: rtl/uart_receiver.sv
// 8N1 UART receiver. Bits are sampled at their centres. Each good byte is
// presented with a one-cycle strobe, and a bad stop bit gives a one-cycle frame_error.
//
// state   | meaning
// S_IDLE  | line idle, waiting for falling edge
// S_START | half-bit wait, confirm start bit still low
// S_DATA  | sample 8 data bits LSB first at bit centres
// S_STOP  | sample stop bit, publish byte or flag error
// S_BREAK | stop bit was low, wait for line to return high
module uart_receiver #(
  parameter int CLKS_PER_BIT = 434
) (
  input logic            clc,
  input logic            res,
  uart_receiver_if.slave bus
);

  localparam int HALF = CLKS_PER_BIT / 2;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

  state_t          state_q, state_d;
  logic            sync1_q, rx_s_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      word_q, word_d;
  logic            done_q, done_d;
  logic            ferr_q, ferr_d;

  always_ff @(posedge clc) begin
    if (res) begin
      state_q <= S_IDLE;
      sync1_q <= 1'b1;
      rx_s_q  <= 1'b1;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      word_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      sync1_q <= bus.RX;
      rx_s_q  <= sync1_q;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      word_q  <= word_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    word_d  = word_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rx_s_q) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end
      S_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          idx_d   = '0;
          // A start bit that is already high again at its centre was a glitch
          state_d = rx_s_q ? S_IDLE : S_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          shift_d[idx_q] = rx_s_q;
          cnt_d          = '0;
          idx_d          = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx_s_q) begin
            word_d  = shift_q;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_BREAK: begin
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.word_receiver        = word_q;
  assign bus.priznak_end_receiver = done_q;
  assign bus.frame_error          = ferr_q;
  assign bus.busy                 = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// Scenario bench for uart_receiver: a frame-level transmitter model feeds RX and
// received bytes are compared against the queue of bytes that were sent with a good stop bit.
module tb_uart_receiver;
  localparam int CPB = 16;

  logic clc = 1'b0;
  logic res;
  always #5 clc = ~clc;

  uart_receiver_if u_if();

  uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
    .clc (clc),
    .res (res),
    .bus (u_if.slave)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] model_word;
  int         ferr_seen = 0;

  always @(negedge clc) begin
    if (u_if.priznak_end_receiver === 1'b1) got_q.push_back(u_if.word_receiver);
    if (u_if.frame_error === 1'b1) ferr_seen++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Line-level transmitter: start 0, data LSB first, stop bit, each CPB cycles
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      u_if.RX = f[i];
      repeat (CPB) @(negedge clc);
    end
    if (stop_bit) begin
      exp_q.push_back(b);
      model_word = b;
    end
  endtask

  task automatic test_reset();
    res = 1'b1;
    u_if.RX = 1'b1;
    repeat (3) @(negedge clc);
    total++; if (u_if.word_receiver !== 8'h00) begin bad++; $display("FAIL reset_word got=%h exp=00", u_if.word_receiver); end
    total++; if (u_if.priznak_end_receiver !== 1'b0) begin bad++; $display("FAIL reset_strobe got=%b exp=0", u_if.priznak_end_receiver); end
    total++; if (u_if.frame_error !== 1'b0) begin bad++; $display("FAIL reset_ferr got=%b exp=0", u_if.frame_error); end
    total++; if (u_if.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", u_if.busy); end
    res = 1'b0;
    model_word = 8'h00;
    repeat (4) @(negedge clc);
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_single();
    int f0;
    f0 = ferr_seen;
    send_frame(8'hA5, 1'b1);
    repeat (10) @(negedge clc);
    total++; if (got_q.size() !== 1) begin bad++; $display("FAIL single_count got=%0d exp=1", got_q.size()); end
    total++; if (got_q.size() < 1 || got_q[0] !== 8'hA5) begin bad++; $display("FAIL single_byte got=%h exp=a5", (got_q.size() > 0) ? got_q[0] : 8'hxx); end
    total++; if (ferr_seen - f0 !== 0) begin bad++; $display("FAIL single_ferr got=%0d exp=0", ferr_seen - f0); end
    total++; if (u_if.word_receiver !== model_word) begin bad++; $display("FAIL single_word got=%h exp=%h", u_if.word_receiver, model_word); end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    int f0;
    f0 = ferr_seen;
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    send_frame(8'h5A, 1'b1);
    repeat (10) @(negedge clc);
    total++; if (got_q.size() !== exp_q.size()) begin bad++; $display("FAIL b2b_count got=%0d exp=%0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL b2b_byte%0d got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
      end
    end
    total++; if (ferr_seen - f0 !== 0) begin bad++; $display("FAIL b2b_ferr got=%0d exp=0", ferr_seen - f0); end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_frame_error();
    int f0;
    f0 = ferr_seen;
    send_frame(8'h3C, 1'b0);
    repeat (40 * CPB) @(negedge clc);
    total++; if (ferr_seen - f0 !== 1) begin bad++; $display("FAIL ferr_count got=%0d exp=1", ferr_seen - f0); end
    total++; if (got_q.size() !== 0) begin bad++; $display("FAIL ferr_nostrobe got=%0d exp=0", got_q.size()); end
    total++; if (u_if.word_receiver !== model_word) begin bad++; $display("FAIL ferr_word got=%h exp=%h", u_if.word_receiver, model_word); end
    total++; if (u_if.busy !== 1'b1) begin bad++; $display("FAIL ferr_busy_held got=%b exp=1", u_if.busy); end
    u_if.RX = 1'b1;
    repeat (10) @(negedge clc);
    total++; if (u_if.busy !== 1'b0) begin bad++; $display("FAIL ferr_busy_release got=%b exp=0", u_if.busy); end
    total++; if (ferr_seen - f0 !== 1 || got_q.size() !== 0) begin bad++; $display("FAIL ferr_after got=%0d/%0d exp=1/0", ferr_seen - f0, got_q.size()); end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_glitch();
    int f0;
    f0 = ferr_seen;
    u_if.RX = 1'b0;
    repeat (5) @(negedge clc);
    u_if.RX = 1'b1;
    @(negedge clc);
    total++; if (u_if.busy !== 1'b1) begin bad++; $display("FAIL glitch_busy_pulse got=%b exp=1", u_if.busy); end
    repeat (20) @(negedge clc);
    total++; if (u_if.busy !== 1'b0) begin bad++; $display("FAIL glitch_busy_idle got=%b exp=0", u_if.busy); end
    total++; if (got_q.size() !== 0 || ferr_seen - f0 !== 0) begin bad++; $display("FAIL glitch_nostrobe got=%0d/%0d exp=0/0", got_q.size(), ferr_seen - f0); end
    send_frame(8'h81, 1'b1);
    repeat (10) @(negedge clc);
    total++; if (got_q.size() !== 1 || got_q[0] !== 8'h81) begin bad++; $display("FAIL glitch_next got=%0d/%h exp=1/81", got_q.size(), (got_q.size() > 0) ? got_q[0] : 8'hxx); end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    logic [7:0] b;
    b = 8'h77;
    u_if.RX = 1'b0;
    repeat (CPB) @(negedge clc);
    for (int i = 0; i < 3; i++) begin
      u_if.RX = b[i];
      repeat (CPB) @(negedge clc);
    end
    res = 1'b1;
    u_if.RX = 1'b1;
    @(negedge clc);
    res = 1'b0;
    model_word = 8'h00;
    total++; if (u_if.word_receiver !== 8'h00) begin bad++; $display("FAIL rstmid_word got=%h exp=00", u_if.word_receiver); end
    total++; if (u_if.busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", u_if.busy); end
    total++; if (u_if.priznak_end_receiver !== 1'b0 || u_if.frame_error !== 1'b0) begin bad++; $display("FAIL rstmid_strobes got=%b%b exp=00", u_if.priznak_end_receiver, u_if.frame_error); end
    repeat (4) @(negedge clc);
    got_q.delete();
    exp_q.delete();
    send_frame(8'hC3, 1'b1);
    repeat (10) @(negedge clc);
    total++; if (u_if.word_receiver !== model_word) begin bad++; $display("FAIL rstmid_next got=%h exp=%h", u_if.word_receiver, model_word); end
    total++; if (got_q.size() !== 1) begin bad++; $display("FAIL rstmid_count got=%0d exp=1", got_q.size()); end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic test_loopback();
    int f0;
    logic [7:0] b;
    f0 = ferr_seen;
    for (int n = 0; n < 256; n++) begin
      b = 8'($urandom);
      send_frame(b, 1'b1);
    end
    repeat (10) @(negedge clc);
    total++; if (got_q.size() !== 256) begin bad++; $display("FAIL loop_count got=%0d exp=256", got_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (i >= got_q.size() || got_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL loop_byte%0d got=%h exp=%h", i, (i < got_q.size()) ? got_q[i] : 8'hxx, exp_q[i]);
      end
    end
    total++; if (ferr_seen - f0 !== 0) begin bad++; $display("FAIL loop_ferr got=%0d exp=0", ferr_seen - f0); end
    total++; if (u_if.word_receiver !== model_word) begin bad++; $display("FAIL loop_word got=%h exp=%h", u_if.word_receiver, model_word); end
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_frame_error();
    test_glitch();
    test_reset_mid();
    test_loopback();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
